// File: rtl/demand_pacer.sv
// demand_pacer: single-chamber VVI/VOO demand pacing core; `PACER_HYST_EN adds sense-triggered escape hysteresis
module demand_pacer #(
    parameter int CNT_W    = 16,
    parameter int LRI_CYC  = 50000,
    parameter int VRP_CYC  = 15000,
    parameter int PW_CYC   = 50,
    parameter int HYST_CYC = 60000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mode,
    input  logic       sense_in,
    output logic       pace_out,
    output logic       sense_evt,
    output logic       refractory,
    output logic [1:0] state,
    output logic [7:0] pace_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, ALERT = 2'd1, PACE = 2'd2, REFRACT = 2'd3} state_t;

    localparam logic [CNT_W-1:0] LRI_M1 = CNT_W'(LRI_CYC - 1);
    localparam logic [CNT_W-1:0] VRP_M1 = CNT_W'(VRP_CYC - 1);
    localparam logic [CNT_W-1:0] PW_M1  = CNT_W'(PW_CYC - 1);

    state_t           cur, nxt;
    logic [CNT_W-1:0] t, t_nxt, esc_m1;
    logic             s1, s2, s3, s_edge, qual, pace_go;

    if (!(PW_CYC >= 1 && PW_CYC < VRP_CYC && VRP_CYC < LRI_CYC && LRI_CYC <= HYST_CYC &&
          longint'(HYST_CYC) < (longint'(1) << CNT_W))) begin : g_bad_params
        $error("demand_pacer: timing parameters out of range");
    end

`ifdef PACER_HYST_EN
    localparam logic [CNT_W-1:0] HYST_M1 = CNT_W'(HYST_CYC - 1);
    logic hyst;
    // Remember whether the most recent event was a qualified sense (stretches the next escape)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hyst <= 1'b0;
        else if (qual) hyst <= 1'b1;
        else if (pace_go) hyst <= 1'b0;
    assign esc_m1 = hyst ? HYST_M1 : LRI_M1;
`else
    assign esc_m1 = LRI_M1;
`endif

    // Two-flop synchroniser followed by a registered rising-edge detector on sense_in
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {s1, s2, s3, s_edge} <= '0;
        end else begin
            s1     <= sense_in;
            s2     <= s1;
            s3     <= s2;
            s_edge <= s2 & ~s3;
        end

    // Next-state and interval timer; sense beats expiry in ALERT, and dropping en overrides all
    always_comb begin
        nxt     = cur;
        t_nxt   = &t ? t : t + 1'b1;
        qual    = 1'b0;
        pace_go = 1'b0;
        case (cur)
            IDLE: if (en) begin
                nxt   = ALERT;
                t_nxt = '0;
            end
            ALERT: if (s_edge && !mode) begin
                nxt   = REFRACT;
                t_nxt = '0;
                qual  = 1'b1;
            end else if (t == esc_m1) begin
                nxt     = PACE;
                t_nxt   = '0;
                pace_go = 1'b1;
            end
            PACE:    if (t == PW_M1) nxt = REFRACT;
            REFRACT: if (t == VRP_M1) nxt = ALERT;
        endcase
        if (!en) begin
            nxt     = IDLE;
            qual    = 1'b0;
            pace_go = 1'b0;
        end
    end

    // State, timer and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur        <= IDLE;
            t          <= '0;
            pace_out   <= 1'b0;
            sense_evt  <= 1'b0;
            refractory <= 1'b0;
            pace_cnt   <= '0;
        end else begin
            cur        <= nxt;
            t          <= t_nxt;
            pace_out   <= nxt == PACE;
            sense_evt  <= qual;
            refractory <= nxt == PACE || nxt == REFRACT;
            if (pace_go && pace_cnt != 8'hff) pace_cnt <= pace_cnt + 8'd1;
        end

    assign state = cur;
endmodule

// File: tb/tb_demand_pacer.sv
// tb_demand_pacer: directed + randomized checks of demand_pacer against an event-timing model (honours `PACER_HYST_EN)
module tb_demand_pacer;
    localparam int LRI = 100, VRP = 30, PW = 4, HYST = 150;
`ifdef PACER_HYST_EN
    localparam int ESC_S = HYST;
`else
    localparam int ESC_S = LRI;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, sense_in = 1'b0;
    logic       pace_out, sense_evt, refractory;
    logic [1:0] state;
    logic [7:0] pace_cnt;

    int vectors = 0, miscompares = 0;

    // Reference model: time of the last event and its kind, escape and refractory windows in cycles
    int         n = 0, last_t = 0, cnt = 0;
    bit         active = 0, virt = 1, last_pace = 0, hflag = 0;
    logic [4:0] hist = '0;
    logic       e_po = 0, e_se = 0, e_rf = 0, last_po = 0;
    logic [1:0] e_st = 0;

    demand_pacer #(.CNT_W(16), .LRI_CYC(LRI), .VRP_CYC(VRP), .PW_CYC(PW), .HYST_CYC(HYST)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sense_in(sense_in),
        .pace_out(pace_out), .sense_evt(sense_evt), .refractory(refractory),
        .state(state), .pace_cnt(pace_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model, given the inputs that were present before that edge
    task automatic model(input bit rs, input bit es, input bit ms, input bit ss);
        int esc, lo;
        hist = {hist[3:0], ss};
        e_se = 1'b0;
        if (!rs) begin
            hist   = '0;
            cnt    = 0;
            hflag  = 0;
            active = 0;
        end
        if (!rs || !es) begin
            active = 0;
            e_po   = 1'b0;
            e_rf   = 1'b0;
            e_st   = 2'd0;
        end else if (!active) begin
            active = 1;
            virt   = 1;
            last_t = n;
            e_po   = 1'b0;
            e_rf   = 1'b0;
            e_st   = 2'd1;
        end else begin
            esc = hflag ? ESC_S : LRI;
            lo  = virt ? last_t + 1 : last_t + VRP + 1;
            if (hist[3] && !hist[4] && !ms && n >= lo && n <= last_t + esc) begin
                last_t = n; virt = 0; last_pace = 0; hflag = 1; e_se = 1'b1;
            end else if (n == last_t + esc) begin
                last_t = n; virt = 0; last_pace = 1; hflag = 0;
                cnt = cnt < 255 ? cnt + 1 : 255;
            end
            e_po = !virt && last_pace && (n - last_t) < PW;
            e_rf = !virt && (n - last_t) < VRP;
            e_st = e_po ? 2'd2 : e_rf ? 2'd3 : 2'd1;
        end
    endtask

    task automatic tick();
        bit rs, es, ms, ss;
        rs = rst_n; es = en; ms = mode; ss = sense_in;
        last_po = pace_out;
        @(posedge clk);
        n++;
        model(rs, es, ms, ss);
        @(negedge clk);
        chk($sformatf("cycle%0d", n), 32'({pace_out, sense_evt, refractory, state, pace_cnt}),
            32'({e_po, e_se, e_rf, e_st, 8'(cnt)}));
    endtask

    task automatic wait_pace(output int k);
        k = 0;
        do begin tick(); k++; end while (!(pace_out && !last_po) && k < 400);
        chk("pace_seen", 32'(pace_out & ~last_po), 32'd1);
    endtask

    task automatic wait_evt(output int k);
        k = 0;
        do begin tick(); k++; end while (!sense_evt && k < 20);
        chk("evt_seen", 32'(sense_evt), 32'd1);
    endtask

    initial begin
        int k, w;
        repeat (3) tick();
        chk("reset", 32'({pace_out, sense_evt, refractory, state, pace_cnt}), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        wait_pace(k); chk("first_pace", 32'(k), 32'(LRI + 1));
        wait_pace(k); chk("period", 32'(k), 32'(LRI));
        w = 0;
        while (pace_out && w < 20) begin tick(); w++; end
        chk("pulse_w", 32'(w), 32'(PW));
        wait_pace(k); chk("period_w", 32'(k), 32'(LRI - PW));
        w = 0;
        while (refractory && w < 60) begin tick(); w++; end
        chk("refr_w", 32'(w), 32'(VRP));
        wait_pace(k); chk("period_r", 32'(k), 32'(LRI - VRP));
        // VVI sense 60 cycles after a pace inhibits and restarts the escape
        repeat (59) tick();
        sense_in = 1'b1; repeat (3) tick(); sense_in = 1'b0;
        wait_evt(k); chk("sense_lat", 32'(k), 32'd1);
        wait_pace(k); chk("vvi_hold", 32'(k), 32'(ESC_S));
        // Sense inside refractory is dropped
        repeat (9) tick();
        sense_in = 1'b1; repeat (3) tick(); sense_in = 1'b0;
        wait_pace(k); chk("refr_ignore", 32'(k), 32'(LRI - 12));
        // VOO ignores sensing
        mode = 1'b1;
        repeat (59) tick();
        sense_in = 1'b1; repeat (3) tick(); sense_in = 1'b0;
        wait_pace(k); chk("voo_pace", 32'(k), 32'(LRI - 62));
        // Sense coinciding with escape expiry wins in VVI
        mode = 1'b0;
        repeat (96) tick();
        sense_in = 1'b1; repeat (3) tick(); sense_in = 1'b0;
        tick();
        chk("coinc_evt", 32'(sense_evt), 32'd1);
        chk("coinc_state", 32'(state), 32'd3);
        chk("coinc_nopace", 32'(pace_out), 32'd0);
        wait_pace(k); chk("after_coinc", 32'(k), 32'(ESC_S));
        // Randomized sensing, mode flips and enable glitches
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) sense_in = ~sense_in;
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            en = $urandom_range(0, 599) != 0;
            tick();
        end
        en = 1'b1; mode = 1'b0; sense_in = 1'b0;
        repeat (5) tick();
        // Enable dropped two cycles into a pulse truncates it
        wait_pace(k); tick();
        en = 1'b0; tick();
        chk("trunc_po", 32'(pace_out), 32'd0);
        chk("trunc_state", 32'(state), 32'd0);
        en = 1'b1;
        // Asynchronous reset mid-pulse
        wait_pace(k); tick();
        rst_n = 1'b0;
        #1;
        chk("async_po", 32'(pace_out), 32'd0);
        chk("async_cnt", 32'(pace_cnt), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) wait_pace(k);
        chk("cnt_sat", 32'(pace_cnt), 32'd255);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
